spi_frame_slave: RTL and testbench
==================================

SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

Interface
REQ-001 Parameter FRAME_W, default 32: frame length in bits, shifted MSB first.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of each input synchronizer.
REQ-003 clk  input  1  system clock; SHALL run at least 8x the SCLK frequency.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sclk  input  1  SPI clock from the external master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 mosi  input  1  SPI master-out data, asynchronous.
REQ-008 data_frame  input  FRAME_W  registered frame from the upstream packer; valid from the cycle after req.
REQ-009 req  output  1  one-cycle pulse to the upstream packer requesting a frame snapshot.
REQ-010 miso  output  1  SPI slave-out data.
REQ-011 miso_oe  output  1  miso output enable; high while a frame is selected.
REQ-012 rx_data  output  FRAME_W  last complete word received on mosi.
REQ-013 rx_valid  output  1  one-cycle pulse; rx_data updated.
REQ-014 frame_err  output  1  one-cycle pulse; frame aborted early.
REQ-015 frame_cnt  output  16  count of completed frames.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 sclk, cs_n and mosi SHALL each pass through a SYNC_STAGES synchronizer; a further register on sclk and cs_n SHALL provide edge detection.
REQ-018 FSM states SHALL be IDLE, REQ, LOAD, SHIFT, DONE.
REQ-019 IDLE->REQ on a synchronized cs_n falling edge.
REQ-020 In REQ, req SHALL be 1 for exactly one cycle; REQ->LOAD unconditionally.
REQ-021 In LOAD, tx_shift SHALL capture data_frame and bit_cnt SHALL clear to 0; LOAD->SHIFT unconditionally.
REQ-022 miso SHALL equal tx_shift[FRAME_W-1] while miso_oe=1, and 0 otherwise.
REQ-023 miso_oe SHALL be 1 in LOAD, SHIFT and DONE.
REQ-024 SHIFT, synchronized sclk rising edge: rx_shift SHALL take {rx_shift[FRAME_W-2:0], mosi_sync} and bit_cnt SHALL increment.
REQ-025 SHIFT, synchronized sclk falling edge: tx_shift SHALL shift left by one, filling with 0.
REQ-026 SHIFT: on the rising edge that brings bit_cnt to FRAME_W, rx_data SHALL load the completed word in the next cycle, rx_valid SHALL pulse once, frame_cnt SHALL increment, and the FSM SHALL go to DONE.
REQ-027 frame_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-028 DONE: further sclk edges SHALL be ignored, with no shift, no count and no pulse.
REQ-029 DONE->IDLE on a synchronized cs_n rising edge.
REQ-030 cs_n rising in REQ, LOAD or SHIFT with bit_cnt<FRAME_W: frame_err SHALL pulse once, rx_data and frame_cnt SHALL remain unchanged, and the FSM SHALL go to IDLE.
REQ-031 If a cs_n rising edge and the final sclk rising edge are detected in the same cycle, the frame SHALL count as complete and frame_err SHALL stay 0.
REQ-032 sclk edges in IDLE SHALL be ignored.
REQ-033 External timing: cs_n fall to first sclk rise SHALL be at least 6 clk periods, so that LOAD completes before the first sample.
REQ-034 req SHALL be asserted only from REQ state, at most once per cs_n assertion.

Reset
REQ-035 While reset=1: FSM in IDLE; req, miso, miso_oe, rx_valid, frame_err and busy are 0; rx_data, tx_shift, rx_shift and bit_cnt are 0; frame_cnt is 0; synchronizer and edge registers are 1 for cs_n and 0 for sclk and mosi.
REQ-036 Reset asserted mid-frame SHALL abort immediately with no rx_valid or frame_err pulse; after release the block SHALL wait for a fresh cs_n falling edge.

Verification
REQ-037 Nominal: data_frame=0xA5C3_0F1E, master shifts 32 bits with mosi=0x1234_5678 -> one req pulse, master reads 0xA5C3_0F1E, rx_data=0x1234_5678, one rx_valid pulse, frame_cnt 0->1.
REQ-038 Abort: cs_n rises after 12 bits -> one frame_err pulse, no rx_valid, rx_data and frame_cnt unchanged, FSM returns to IDLE.
REQ-039 Over-clocking: 40 sclk cycles in one frame -> first 32 bits only, exactly one rx_valid, miso=0 for the extra bits.
REQ-040 Back-to-back: two frames with a minimum cs_n high gap of 4 clk and data_frame 0x0000_0001 then 0xFFFF_FFFF -> two req pulses and both values read correctly.
REQ-041 Wrap: preset frame_cnt by running 65536 frames, or by forced preload -> 0xFFFF->0x0000 on the next completed frame.
REQ-042 Reset mid-frame: assert reset at bit 20 and release, then run a full frame -> no pulses during reset, next frame nominal.

Source files
------------

// File: rtl/spi_frame_slave.sv
// spi_frame_slave
//   SPI mode-0 slave that exchanges one FRAME_W-bit word per chip-select
//   assertion. On cs_n falling it asks the upstream packer for a snapshot
//   (req), loads it, and shifts it out MSB first on miso. At the same time it
//   collects the mosi word into rx_data. All SPI inputs are oversampled by clk.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   sclk, cs_n, mosi  raw SPI inputs (asynchronous to clk)
//   data_frame        frame from the packer, valid the cycle after req
//   req               one-cycle snapshot request to the packer
//   miso, miso_oe     SPI data out and its output enable
//   rx_data, rx_valid last complete received word and its update pulse
//   frame_err         pulse when cs_n rises before the frame completes
//   frame_cnt         count of completed frames (wraps)
//   busy              FSM is not IDLE
module spi_frame_slave #(
    parameter int FRAME_W     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sclk,
    input  logic               cs_n,
    input  logic               mosi,
    input  logic [FRAME_W-1:0] data_frame,
    output logic               req,
    output logic               miso,
    output logic               miso_oe,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    output logic               frame_err,
    output logic [15:0]        frame_cnt,
    output logic               busy
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_q, cs_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                   last_rise;
    logic                   complete;
    logic [FRAME_W-1:0]     tx_shift, rx_shift;
    logic [CNT_W-1:0]       bit_cnt;

    // Input synchronizers plus one extra stage on sclk/cs_n for edge detect.
    // cs_n idles high so its chain resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync[0] <= sclk;
            cs_sync[0]   <= cs_n;
            mosi_sync[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;

    // Sampling edge that completes the word.
    assign last_rise = (state == S_SHIFT) && sclk_rise &&
                       (bit_cnt == CNT_W'(FRAME_W - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cs_fall) state_nxt = S_REQ;
            S_REQ:   state_nxt = cs_rise ? S_IDLE : S_LOAD;
            S_LOAD:  state_nxt = cs_rise ? S_IDLE : S_SHIFT;
            // A deselect that lands with the final sample still completes the
            // frame, but there is no later cs_n rise to leave DONE on, so go
            // straight back to IDLE.
            S_SHIFT: if (last_rise)    state_nxt = cs_rise ? S_IDLE : S_DONE;
                     else if (cs_rise) state_nxt = S_IDLE;
            S_DONE:  if (cs_rise) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        req     = (state == S_REQ);
        miso_oe = (state == S_LOAD) || (state == S_SHIFT) || (state == S_DONE);
        busy    = (state != S_IDLE);
        miso    = miso_oe & tx_shift[FRAME_W-1];
    end

    // Datapath. rx_data is taken from rx_shift one cycle after the final
    // sample, once the last bit has landed in the shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            complete  <= 1'b0;
        end else begin
            complete  <= last_rise;
            rx_valid  <= complete;
            frame_err <= cs_rise && !last_rise &&
                         ((state == S_REQ) || (state == S_LOAD) || (state == S_SHIFT));
            if (complete) begin
                rx_data   <= rx_shift;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (state == S_LOAD) begin
                tx_shift <= data_frame;
                bit_cnt  <= '0;
            end else if (state == S_SHIFT) begin
                if (sclk_rise) begin
                    rx_shift <= {rx_shift[FRAME_W-2:0], mosi_s};
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                    // Every bit has been sampled by the master; drive 0 for
                    // any over-clocked bits that follow.
                    if (last_rise) tx_shift <= '0;
                end else if (sclk_fall) begin
                    tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Testbench for spi_frame_slave: an SPI master model drives frames, a packer
// model answers req, and a word-level reference model predicts miso bits,
// rx_data, frame_cnt and the req/rx_valid/frame_err pulse counts per frame.
module tb_spi_frame_slave;

    localparam int FW   = 32;
    localparam int HALF = 6;   // sclk half period in clk cycles (12x ratio)

    logic          clk = 1'b0;
    logic          reset;
    logic          sclk, cs_n, mosi;
    logic [FW-1:0] data_frame;
    logic          req, miso, miso_oe, rx_valid, frame_err, busy;
    logic [FW-1:0] rx_data;
    logic [15:0]   frame_cnt;

    spi_frame_slave #(.FRAME_W(FW), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .data_frame (data_frame),
        .req        (req),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Upstream packer: registers the pending word when asked.
    logic [FW-1:0] pending;
    always @(posedge clk) if (req) data_frame <= pending;

    // Pulse monitors
    int n_req = 0, n_rxv = 0, n_err = 0;
    always @(posedge clk) begin
        if (req)       n_req <= n_req + 1;
        if (rx_valid)  n_rxv <= n_rxv + 1;
        if (frame_err) n_err <= n_err + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state
    logic [FW-1:0] exp_rx;
    logic [15:0]   exp_cnt;

    // Master: one frame of nbits sclk cycles, returning bits read on miso.
    // rst_at >= 0 asserts reset at the start of that bit and ends the frame.
    task automatic spi_frame(input logic [FW-1:0] d, input logic [FW-1:0] m,
                             input int nbits, input int gap, input int rst_at,
                             output logic [63:0] rd);
        rd      = '0;
        pending = d;
        @(negedge clk) cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk("rst_busy",  busy,      1'b0);
                chk("rst_oe",    miso_oe,   1'b0);
                chk("rst_miso",  miso,      1'b0);
                chk("rst_rxd",   rx_data,   '0);
                chk("rst_cnt",   frame_cnt, '0);
                cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
                repeat (4) @(negedge clk);
                reset = 1'b0;
                repeat (gap) @(negedge clk);
                return;
            end
            mosi = (i < FW) ? m[FW-1-i] : 1'($urandom);
            repeat (HALF) @(negedge clk);
            rd   = {rd[62:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Run a frame and compare against the word-level model.
    task automatic run_check(input string tag, input logic [FW-1:0] d, input logic [FW-1:0] m,
                             input int nbits, input int gap);
        logic [63:0] rd;
        int r0, v0, e0;
        logic [63:0] dw;
        r0 = n_req; v0 = n_rxv; e0 = n_err;
        dw = 64'(d);
        spi_frame(d, m, nbits, gap, -1, rd);
        chk({tag, "_req"}, 64'(n_req - r0), 64'd1);
        if (nbits >= FW) begin
            exp_rx  = m;
            exp_cnt = exp_cnt + 16'd1;
            chk({tag, "_miso"},  rd >> (nbits - FW), dw);
            chk({tag, "_extra"}, rd & ((64'd1 << (nbits - FW)) - 64'd1), 64'd0);
            chk({tag, "_rxv"},   64'(n_rxv - v0), 64'd1);
            chk({tag, "_err"},   64'(n_err - e0), 64'd0);
        end else begin
            chk({tag, "_miso"},  rd, dw >> (FW - nbits));
            chk({tag, "_rxv"},   64'(n_rxv - v0), 64'd0);
            chk({tag, "_err"},   64'(n_err - e0), 64'd1);
        end
        chk({tag, "_rxd"},  rx_data,   exp_rx);
        chk({tag, "_cnt"},  frame_cnt, exp_cnt);
        chk({tag, "_busy"}, busy,      1'b0);
        chk({tag, "_oe"},   miso_oe,   1'b0);
    endtask

    initial begin
        logic [63:0] rd;
        int v0, e0, nb;
        reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        pending = '0; data_frame = '0;
        exp_rx = '0; exp_cnt = '0;
        repeat (4) @(negedge clk);
        chk("reset_req",  req,       1'b0);
        chk("reset_oe",   miso_oe,   1'b0);
        chk("reset_miso", miso,      1'b0);
        chk("reset_busy", busy,      1'b0);
        chk("reset_rxv",  rx_valid,  1'b0);
        chk("reset_err",  frame_err, 1'b0);
        chk("reset_rxd",  rx_data,   '0);
        chk("reset_cnt",  frame_cnt, '0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // sclk toggling with cs_n high must do nothing
        for (int i = 0; i < 4; i++) begin
            repeat (HALF) @(negedge clk) sclk = ~sclk;
        end
        chk("idle_sclk_busy", busy, 1'b0);
        chk("idle_sclk_req",  64'(n_req), 64'd0);

        run_check("nominal",  32'hA5C3_0F1E, 32'h1234_5678, 32, 8);
        run_check("abort12",  32'hDEAD_BEEF, 32'hCAFE_F00D, 12, 8);
        run_check("over40",   32'h8000_0001, 32'h7FFF_FFFE, 40, 8);
        run_check("b2b_a",    32'h0000_0001, 32'h0F0F_0F0F, 32, 4);
        run_check("b2b_b",    32'hFFFF_FFFF, 32'hF0F0_F0F0, 32, 4);

        // Reset mid-frame at bit 20
        v0 = n_rxv; e0 = n_err;
        spi_frame(32'h1357_9BDF, 32'h2468_ACE0, 32, 8, 20, rd);
        exp_rx = '0; exp_cnt = '0;
        chk("midrst_rxv", 64'(n_rxv - v0), 64'd0);
        chk("midrst_err", 64'(n_err - e0), 64'd0);
        chk("midrst_busy", busy, 1'b0);
        run_check("post_rst", 32'h0BAD_CAFE, 32'h5555_AAAA, 32, 8);

        // Wrap: preload the counter to its maximum
        @(negedge clk) force dut.frame_cnt = 16'hFFFF;
        @(negedge clk) release dut.frame_cnt;
        @(negedge clk);
        exp_cnt = 16'hFFFF;
        chk("preload_cnt", frame_cnt, exp_cnt);
        run_check("wrap", 32'h0000_FFFF, 32'hFFFF_0000, 32, 8);

        // Random frames
        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 2))
                0:       nb = $urandom_range(1, FW - 1);
                1:       nb = FW;
                default: nb = $urandom_range(FW + 1, FW + 8);
            endcase
            run_check($sformatf("rnd%0d", k), $urandom, $urandom, nb, $urandom_range(4, 10));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
